dyn_partition_stepper: RTL and testbench

Parametrised, clocked transition-system stepper for dynamic-partition fixpoint checking. Holds NUM_PART counters of CNT_W bits plus a phase register; each step increments only the counter selected by the phase, holds the rest, then advances the phase. It runs from a loaded initial state until the state equals a target (hit) or a step bound expires (timeout). It sits beside the combinational transition checkers as their bounded, sequential counterpart for simulation cross-checking.

---
 rtl/dyn_part_pkg.sv | 25 ++
 rtl/dyn_part_counter.sv | 32 +++
 rtl/dyn_partition_stepper.sv | 107 ++++++++++
 tb/tb_dyn_partition_stepper.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/dyn_part_pkg.sv
// Shared types and state-packing helpers for the dynamic-partition stepper.
// Packed state layout: {phase, cnt[NUM_PART-1], ..., cnt[0]}.
package dyn_part_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HIT, S_TIMEOUT} fsm_e;

  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_SAT  = 1'b1;

  // Widest packed state the helpers accept; callers zero-extend into it.
  localparam int MAX_ST_W = 256;

  function automatic logic [31:0] get_cnt(input logic [MAX_ST_W-1:0] st,
                                          input int idx, input int cnt_w);
    logic [MAX_ST_W-1:0] sh;
    sh = st >> (idx * cnt_w);
    get_cnt = 32'(sh & ((MAX_ST_W'(1) << cnt_w) - MAX_ST_W'(1)));
  endfunction

  function automatic logic [31:0] get_phase(input logic [MAX_ST_W-1:0] st,
                                            input int num_part, input int cnt_w);
    get_phase = 32'(st >> (num_part * cnt_w));
  endfunction

endpackage

// File: rtl/dyn_part_counter.sv
// One partition counter slice: loads, or increments (wrap or saturate) when selected.
module dyn_part_counter
  import dyn_part_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             step,
  input  logic             inc,
  input  logic             sat,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] inc_val;

  assign inc_val = (sat && (&cnt_q)) ? cnt_q : cnt_q + CNT_W'(1);
  // Look-ahead value lets the top compare the post-step state before it is committed.
  assign cnt_nxt = inc ? inc_val : cnt_q;
  assign cnt     = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt_q <= '0;
    else if (load)        cnt_q <= load_val;
    else if (step && inc) cnt_q <= inc_val;
  end

endmodule

// File: rtl/dyn_partition_stepper.sv
// Bounded sequential stepper: round-robin counter increments from a loaded state
// until the state equals the target (hit) or the step bound expires (timeout).
module dyn_partition_stepper
  import dyn_part_pkg::*;
#(
  parameter int NUM_PART  = 2,
  parameter int CNT_W     = 3,
  parameter int SAT_MODE  = 0,
  parameter int MAX_STEPS = 16,
  parameter int PH_W      = $clog2(NUM_PART),
  parameter int ST_W      = NUM_PART*CNT_W + PH_W,
  parameter int SC_W      = $clog2(MAX_STEPS+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [ST_W-1:0] init_state,
  input  logic [ST_W-1:0] target_state,
  input  logic            step_en,
  output logic [ST_W-1:0] state,
  output logic [PH_W-1:0] active,
  output logic            busy,
  output logic            hit,
  output logic            timeout,
  output logic [SC_W-1:0] step_count
);

  localparam int CW = NUM_PART*CNT_W;

  fsm_e fsm_q, fsm_d;
  logic [PH_W-1:0] phase_q, phase_nxt, ld_phase_raw, ld_phase;
  logic [SC_W-1:0] sc_q;
  logic [NUM_PART-1:0][CNT_W-1:0] cnt_q, cnt_nxt;
  logic [ST_W-1:0] ld_st, step_st;
  logic start_acc, do_step, last_step;

  assign start_acc = start && (fsm_q != S_RUN);
  assign do_step   = (fsm_q == S_RUN) && step_en;
  assign last_step = (32'(sc_q) + 1) == MAX_STEPS;

  // Out-of-range phase in the loaded state folds back to partition 0.
  assign ld_phase_raw = PH_W'(get_phase(MAX_ST_W'(init_state), NUM_PART, CNT_W));
  assign ld_phase     = (32'(ld_phase_raw) >= NUM_PART) ? '0 : ld_phase_raw;
  assign ld_st        = {ld_phase, init_state[CW-1:0]};

  assign phase_nxt = (32'(phase_q) == NUM_PART-1) ? '0 : phase_q + PH_W'(1);
  assign step_st   = {phase_nxt, cnt_nxt};

  for (genvar i = 0; i < NUM_PART; i++) begin : g_part
    dyn_part_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (start_acc),
      .load_val (CNT_W'(get_cnt(MAX_ST_W'(init_state), i, CNT_W))),
      .step     (do_step),
      .inc      (32'(phase_q) == i),
      .sat      (SAT_MODE != 0),
      .cnt      (cnt_q[i]),
      .cnt_nxt  (cnt_nxt[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      sc_q    <= '0;
    end else if (start_acc) begin
      phase_q <= ld_phase;
      sc_q    <= '0;
    end else if (do_step) begin
      phase_q <= phase_nxt;
      sc_q    <= sc_q + SC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= S_IDLE;
    else     fsm_q <= fsm_d;
  end

  // Hit takes priority over timeout when the final permitted step lands on target.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_RUN: begin
        if (step_en) begin
          if (step_st == target_state) fsm_d = S_HIT;
          else if (last_step)          fsm_d = S_TIMEOUT;
        end
      end
      default: begin
        if (start) fsm_d = (ld_st == target_state) ? S_HIT : S_RUN;
      end
    endcase
  end

  always_comb begin
    busy    = (fsm_q == S_RUN);
    hit     = (fsm_q == S_HIT);
    timeout = (fsm_q == S_TIMEOUT);
  end

  assign state      = {phase_q, cnt_q};
  assign active     = phase_q;
  assign step_count = sc_q;

endmodule

// File: tb/tb_dyn_partition_stepper.sv
// Bench: a wrap-mode and a saturate-mode stepper share stimulus; each is checked
// every cycle against an array-based model of the counters, phase and run status.
module tb_dyn_partition_stepper;

  localparam int NP = 2, CW = 3, MS = 8;
  localparam int STW = NP*CW + 1;

  logic clk = 0, rst = 0, start = 0, step_en = 0;
  logic [STW-1:0] init_state = '0, target_state = '0;
  logic [STW-1:0] state_w, state_s;
  logic active_w, active_s;
  logic busy_w, busy_s, hit_w, hit_s, to_w, to_s;
  logic [3:0] sc_w, sc_s;

  int checks = 0, failures = 0;

  // Model: index 0 = wrap DUT, 1 = saturate DUT. status 0 idle,1 run,2 hit,3 timeout.
  int mc[2][NP];
  int mph[2], msc[2], mstat[2];

  always #5 clk = ~clk;

  dyn_partition_stepper #(.NUM_PART(NP), .CNT_W(CW), .SAT_MODE(0), .MAX_STEPS(MS)) dut_w (
    .clk(clk), .rst(rst), .start(start), .init_state(init_state),
    .target_state(target_state), .step_en(step_en), .state(state_w),
    .active(active_w), .busy(busy_w), .hit(hit_w), .timeout(to_w), .step_count(sc_w));

  dyn_partition_stepper #(.NUM_PART(NP), .CNT_W(CW), .SAT_MODE(1), .MAX_STEPS(MS)) dut_s (
    .clk(clk), .rst(rst), .start(start), .init_state(init_state),
    .target_state(target_state), .step_en(step_en), .state(state_s),
    .active(active_s), .busy(busy_s), .hit(hit_s), .timeout(to_s), .step_count(sc_s));

  function automatic int mpack(int m);
    return (mph[m] << (NP*CW)) | (mc[m][1] << CW) | mc[m][0];
  endfunction

  task automatic mreset();
    for (int m = 0; m < 2; m++) begin
      for (int p = 0; p < NP; p++) mc[m][p] = 0;
      mph[m] = 0; msc[m] = 0; mstat[m] = 0;
    end
  endtask

  task automatic medge();
    int v, p;
    for (int m = 0; m < 2; m++) begin
      if (start && mstat[m] != 1) begin
        v = int'(init_state);
        mc[m][0] = v % 8;
        mc[m][1] = (v / 8) % 8;
        mph[m]   = (v / 64) % NP;
        msc[m]   = 0;
        mstat[m] = (mpack(m) == int'(target_state)) ? 2 : 1;
      end else if (mstat[m] == 1 && step_en) begin
        p = mph[m];
        if (m == 1) mc[m][p] = (mc[m][p] == 7) ? 7 : mc[m][p] + 1;
        else        mc[m][p] = (mc[m][p] + 1) % 8;
        mph[m] = (p + 1) % NP;
        msc[m]++;
        if (mpack(m) == int'(target_state)) mstat[m] = 2;
        else if (msc[m] == MS)              mstat[m] = 3;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".w.state"}, 32'(state_w), 32'(mpack(0)));
    chk({tag, ".w.sc"},    32'(sc_w),    32'(msc[0]));
    chk({tag, ".w.act"},   32'(active_w), 32'(mph[0]));
    chk({tag, ".w.flags"}, {29'd0, busy_w, hit_w, to_w},
        {29'd0, mstat[0] == 1, mstat[0] == 2, mstat[0] == 3});
    chk({tag, ".s.state"}, 32'(state_s), 32'(mpack(1)));
    chk({tag, ".s.sc"},    32'(sc_s),    32'(msc[1]));
    chk({tag, ".s.act"},   32'(active_s), 32'(mph[1]));
    chk({tag, ".s.flags"}, {29'd0, busy_s, hit_s, to_s},
        {29'd0, mstat[1] == 1, mstat[1] == 2, mstat[1] == 3});
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    medge();
    #1;
    check_all(tag);
  endtask

  function automatic logic [STW-1:0] pk(int ph, int c1, int c0);
    return STW'((ph << 6) | (c1 << 3) | c0);
  endfunction

  // Launch a run and step until both models finish, within a fixed cycle bound.
  task automatic run(input string tag, input logic [STW-1:0] ini, input logic [STW-1:0] tgt,
                     input bit rnd_en);
    init_state = ini; target_state = tgt; start = 1; step_en = 0;
    tick({tag, ".load"});
    start = 0;
    for (int c = 0; c < 40 && (mstat[0] == 1 || mstat[1] == 1); c++) begin
      step_en = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
      tick(tag);
    end
    step_en = 0;
  endtask

  initial begin
    rst = 1;
    mreset();
    #1;
    check_all("reset");
    #12 rst = 0;
    @(negedge clk);

    run("t1", pk(0,0,0), pk(1,0,1), 0);
    chk("t1.hit", {31'd0, hit_w}, 32'd1);
    chk("t1.sc", 32'(sc_w), 32'd1);
    tick("t1.hold");
    chk("t1.busy", {31'd0, busy_w}, 32'd0);

    run("t2", pk(0,0,0), pk(0,3,3), 0);
    chk("t2.sc", 32'(sc_w), 32'd6);
    chk("t2.hit", {31'd0, hit_w}, 32'd1);

    run("t3", pk(0,0,0), pk(0,0,7), 0);
    chk("t3.to", {31'd0, to_w}, 32'd1);
    chk("t3.sc", 32'(sc_w), 32'd8);
    chk("t3.state", 32'(state_w), 32'(pk(0,4,4)));

    run("t4", pk(0,0,7), pk(0,2,7), 0);
    chk("t4.s.hit", {31'd0, hit_s}, 32'd1);
    chk("t4.s.sc", 32'(sc_s), 32'd4);
    chk("t4.s.state", 32'(state_s), 32'(pk(0,2,7)));

    init_state = pk(1,5,2); target_state = pk(1,5,2); start = 1;
    tick("t5.load");
    start = 0;
    chk("t5.hit", {31'd0, hit_w}, 32'd1);
    chk("t5.sc", 32'(sc_w), 32'd0);
    step_en = 1;
    tick("t5.frozen");
    chk("t5.state", 32'(state_w), 32'(pk(1,5,2)));
    step_en = 0;

    run("t6.toggle", pk(0,1,1), pk(0,7,6), 1);

    // start during RUN is ignored; the run continues unchanged.
    init_state = pk(0,0,0); target_state = pk(0,5,5); start = 1;
    tick("t7.load");
    init_state = pk(1,6,6);
    step_en = 1;
    tick("t7.ign0");
    tick("t7.ign1");
    start = 0;
    tick("t7.run");

    // Asynchronous reset between edges.
    #2 rst = 1;
    #1;
    mreset();
    check_all("t8.rst");
    chk("t8.state", 32'(state_w), 32'd0);
    chk("t8.busy", {31'd0, busy_w}, 32'd0);
    rst = 0;
    step_en = 0;
    tick("t8.after");

    for (int r = 0; r < 20; r++) begin
      run("rnd", STW'($urandom), STW'($urandom), r[0]);
      tick("rnd.idle");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
